// File: rtl/present_pkg.sv
// ============================================================================
//  Module      : present_pkg
//  Description : Shared widths, FSM state encoding and PRESENT cipher helper
//                functions (S-box layer, bit permutation, key schedule) used
//                by the PRESENT-128 stream wrapper and its encryption core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_pkg;

    localparam int PRESENT_BLK_W  = 64;
    localparam int PRESENT_KEY_W  = 128;
    localparam int PRESENT_WORD_W = 32;
    localparam int PRESENT_ROUNDS = 32;

    typedef enum logic [2:0] {
        FILL_HI = 3'd0,
        FILL_LO = 3'd1,
        LOAD    = 3'd2,
        WAIT    = 3'd3,
        OUT_HI  = 3'd4,
        OUT_LO  = 3'd5
    } present_state_e;

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [PRESENT_BLK_W-1:0] present_slayer(input logic [PRESENT_BLK_W-1:0] x);
        logic [PRESENT_BLK_W-1:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = present_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays in place.
    function automatic logic [PRESENT_BLK_W-1:0] present_player(input logic [PRESENT_BLK_W-1:0] x);
        logic [PRESENT_BLK_W-1:0] y;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        return y;
    endfunction

    // 128-bit key schedule: rotate left 61, S-box the top two nibbles,
    // fold the round counter into bits [66:62].
    function automatic logic [PRESENT_KEY_W-1:0] present_key_update(
        input logic [PRESENT_KEY_W-1:0] k,
        input logic [4:0]               rc
    );
        logic [PRESENT_KEY_W-1:0] r;
        r          = {k[66:0], k[127:67]};
        r[127:124] = present_sbox(r[127:124]);
        r[123:120] = present_sbox(r[123:120]);
        r[66:62]   = r[66:62] ^ rc;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/PRESENT_ENCRYPT.sv
// ============================================================================
//  Module      : PRESENT_ENCRYPT
//  Description : Iterative PRESENT-128 encryption core, one round per clock.
//                A load pulse captures key and plaintext; ROUNDS-1 full rounds
//                follow, then the final round-key addition, after which done
//                rises and the ciphertext is held until the next load.
//                The core has no reset; its outputs are meaningful only after
//                a load.
//  Ports       : clk_i  - clock
//                load_i - start a new block (one-cycle pulse)
//                key_i  - 128-bit cipher key, sampled on load
//                data_i - 64-bit plaintext, sampled on load
//                data_o - 64-bit ciphertext, valid while done_o is high
//                done_o - encryption complete, cleared by the next load
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module PRESENT_ENCRYPT
    import present_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic                     clk_i,
    input  logic                     load_i,
    input  logic [PRESENT_KEY_W-1:0] key_i,
    input  logic [PRESENT_BLK_W-1:0] data_i,
    output logic [PRESENT_BLK_W-1:0] data_o,
    output logic                     done_o
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    logic [PRESENT_BLK_W-1:0] state_q;
    logic [PRESENT_BLK_W-1:0] state_d;
    logic [PRESENT_KEY_W-1:0] key_q;
    logic [PRESENT_KEY_W-1:0] key_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     run_q;
    logic                     done_q;

    assign state_d = present_player(present_slayer(state_q ^ key_q[127:64]));
    assign key_d   = present_key_update(key_q, 5'(cnt_q));

    // cnt_q holds the index of the round key currently in key_q; the last
    // index only gets the whitening XOR, no S-box/permutation.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            state_q <= data_i;
            key_q   <= key_i;
            cnt_q   <= CNT_W'(1);
            run_q   <= 1'b1;
            done_q  <= 1'b0;
        end else if (run_q) begin
            if (cnt_q == CNT_W'(ROUNDS)) begin
                state_q <= state_q ^ key_q[127:64];
                run_q   <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= state_d;
                key_q   <= key_d;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign data_o = state_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/present_stream_wrap.sv
// ============================================================================
//  Module      : present_stream_wrap
//  Description : Streaming wrapper around PRESENT_ENCRYPT. Assembles two
//                32-bit plaintext words (high word first) into a block, runs
//                the core, and returns the ciphertext as two 32-bit words.
//                Optional CBC chaining is compiled in with PRESENT_CBC_EN.
//  Ports       : clk, rst            - clock, async active-high reset
//                key_in, iv_in       - key / chaining IV, taken on key_load
//                key_load            - load request, honoured in FILL_HI only
//                s_data/s_valid/s_ready - plaintext word slave port
//                m_data/m_valid/m_ready - ciphertext word master port
//                busy                - high in every state except FILL_HI
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_stream_wrap
    import present_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESENT_KEY_W-1:0]  key_in,
    input  logic [PRESENT_BLK_W-1:0]  iv_in,
    input  logic                      key_load,
    input  logic [PRESENT_WORD_W-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [PRESENT_WORD_W-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy
);

    present_state_e            state_q;
    logic [PRESENT_KEY_W-1:0]  key_q;
    logic [PRESENT_BLK_W-1:0]  blk_q;
    logic [PRESENT_BLK_W-1:0]  ct_q;
    logic [PRESENT_WORD_W-1:0] m_data_q;
    logic                      m_valid_q;
    logic                      busy_q;
    logic                      load_q;

    logic [PRESENT_BLK_W-1:0]  core_pt;
    logic [PRESENT_BLK_W-1:0]  core_ct;
    logic                      core_done;

`ifdef PRESENT_CBC_EN
    logic [PRESENT_BLK_W-1:0]  chain_q;
    assign core_pt = blk_q ^ chain_q;
`else
    logic unused_iv;
    assign unused_iv = ^iv_in;
    assign core_pt   = blk_q;
`endif

    // key_load wins over a plaintext word offered in the same FILL_HI cycle.
    assign s_ready = ((state_q == FILL_HI) && !key_load) || (state_q == FILL_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL_HI;
            key_q     <= '0;
            blk_q     <= '0;
            ct_q      <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
`ifdef PRESENT_CBC_EN
            chain_q   <= '0;
`endif
        end else begin
            case (state_q)
                FILL_HI: begin
                    if (key_load) begin
                        key_q   <= key_in;
`ifdef PRESENT_CBC_EN
                        chain_q <= iv_in;
`endif
                    end else if (s_valid) begin
                        blk_q[63:32] <= s_data;
                        busy_q       <= 1'b1;
                        state_q      <= FILL_LO;
                    end
                end
                FILL_LO: begin
                    if (s_valid) begin
                        blk_q[31:0] <= s_data;
                        load_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // The load edge cleared core_done, so this is the new block.
                    if (core_done) begin
                        ct_q      <= core_ct;
                        m_data_q  <= core_ct[63:32];
                        m_valid_q <= 1'b1;
                        state_q   <= OUT_HI;
                    end
                end
                OUT_HI: begin
                    if (m_ready) begin
                        m_data_q <= ct_q[31:0];
                        state_q  <= OUT_LO;
                    end
                end
                OUT_LO: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= FILL_HI;
`ifdef PRESENT_CBC_EN
                        chain_q   <= ct_q;
`endif
                    end
                end
                default: begin
                    state_q <= FILL_HI;
                end
            endcase
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;

    PRESENT_ENCRYPT #(
        .ROUNDS (ROUNDS)
    ) u_core (
        .clk_i  (clk),
        .load_i (load_q),
        .key_i  (key_q),
        .data_i (core_pt),
        .data_o (core_ct),
        .done_o (core_done)
    );

endmodule

`default_nettype wire

// File: doc/present_stream_wrap.md
# present_stream_wrap

Streaming front/back end for the iterative PRESENT-128 encryption core. Accepts plaintext as 32-bit words over a valid/ready slave port and assembles 64-bit blocks. Drives the core's `load`, waits for its `done`, and returns ciphertext as 32-bit words over a valid/ready master port. Sits between the bus-side DMA/FIFO and the `PRESENT_ENCRYPT` instance, which it contains.

## Interface
- `ROUNDS`, 32: round count passed to the core. Block latency is derived from it.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_in` in 128: cipher key, sampled on an accepted `key_load`.
- `iv_in` in 64: chaining IV, sampled with the key. Ignored unless CBC is compiled in.
- `key_load` in 1: key/IV load request. Honoured only in FILL_HI.
- `s_data` in 32: plaintext word. The first word of a block is bits [63:32].
- `s_valid` in 1: plaintext word valid.
- `s_ready` out 1: plaintext word accepted when `s_valid & s_ready`.
- `m_data` out 32: ciphertext word. The first word of a block is bits [63:32].
- `m_valid` out 1: ciphertext word valid.
- `m_ready` in 1: ciphertext word consumed when `m_valid & m_ready`.
- `busy` out 1: high in every state except FILL_HI.

## Operation
- Registers: `key_r` (128), `chain_r` (64), `blk_r` (64), `ct_r` (64). All reset to 0.
- States and transitions:
  - FILL_HI: on a handshake, `blk_r[63:32] <= s_data` and go to FILL_LO. On an accepted `key_load`, `key_r <= key_in` and `chain_r <= iv_in`.
  - FILL_LO: on a handshake, `blk_r[31:0] <= s_data` and go to LOAD.
  - LOAD: assert core `load` for exactly one cycle, then go to WAIT. The core receives `key_r`, and `blk_r` (ECB) or `blk_r ^ chain_r` (CBC).
  - WAIT: when core `done`=1, `ct_r <= core out_data`, then go to OUT_HI. The LOAD edge clears core `done`, so a stale `done` is never seen here.
  - OUT_HI: `m_valid`=1, `m_data=ct_r[63:32]`. On a handshake go to OUT_LO.
  - OUT_LO: `m_valid`=1, `m_data=ct_r[31:0]`. On a handshake go to FILL_HI. Under CBC, `chain_r <= ct_r` on this edge.
- `s_ready` is `(FILL_HI & ~key_load) | FILL_LO`. `key_load` has priority over a word in the same cycle.
- `key_load` in any state other than FILL_HI is ignored and dropped. No error is flagged.
- `m_data` holds stable while `m_valid & ~m_ready`.
- The core itself has no reset. After `rst`, the FSM ignores core outputs until its own next LOAD.

## Timing
- Reset values: state FILL_HI, `s_ready`=1, `m_valid`=0, `m_data`=0, `busy`=0, core `load`=0.
- `rst` asserted mid-block (any state) aborts the block immediately. The partial block and any pending output are discarded, and the key and chain are zeroed.
- Low word accepted at edge E:
  - `load` high in the cycle after E.
  - Core `done` rises at E+1+ROUNDS.
  - `ct_r` is captured at E+2+ROUNDS.
  - `m_valid` is high from that point, i.e. ROUNDS+2 edges after E (34 edges at default).
- With no stalls, the minimum block period is ROUNDS+6 cycles (38 at default).
- Stalls on `s_valid` or `m_ready` extend only the FILL and OUT states. WAIT length is fixed.

## Configuration
- `PRESENT_CBC_EN` defined:
  - The core input is `blk_r ^ chain_r`.
  - `chain_r` updates to the ciphertext at each OUT_LO handshake.
  - `key_load` re-seeds `chain_r` from `iv_in`.
- `PRESENT_CBC_EN` undefined:
  - ECB only. The core input is `blk_r`.
  - `chain_r` and its XOR are not built, and `iv_in` is unused.

## Structure
- Shared `present_pkg` holds:
  - the FSM state enum (FILL_HI, FILL_LO, LOAD, WAIT, OUT_HI, OUT_LO);
  - `PRESENT_BLK_W`=64, `PRESENT_KEY_W`=128, `PRESENT_WORD_W`=32;
  - the default round count 32.
- One sub-module instance: `PRESENT_ENCRYPT`, with `ROUNDS` passed through. Everything else is flat in this block.

## Test plan
- Reset, `key_load` with key 0, then words 0x00000000 ×2:
  - ECB and CBC (IV 0) give 0x96db702a then 0x2e6900af;
  - `m_valid` rises 34 edges after the low-word handshake.
- `m_ready` held low for 10 cycles in OUT_HI:
  - `m_data` stays 0x96db702a;
  - `s_ready`=0 throughout;
  - the next block is accepted only after OUT_LO completes.
- CBC, IV 0, key 0, two zero blocks:
  - block 2 ciphertext equals the encryption of 0x96db702a2e6900af, checked against the software model;
  - ECB build emits 0x96db702a2e6900af twice.
- `key_load` and `s_valid` in the same FILL_HI cycle:
  - key is taken, word not taken (`s_ready`=0);
  - the word is accepted next cycle.
- `key_load` pulsed during WAIT: ignored, and the ciphertext uses the old key.
- `rst` asserted in WAIT and in OUT_LO:
  - all outputs return to their reset values asynchronously;
  - the next full block after reset produces the correct ciphertext.
